// File: rtl/image_pipeline_pkg.sv
// Shared definitions for the image pipeline: AXI-Lite register map,
// default result buffer base, capture FSM encoding and response codes.
package image_pipeline_pkg;

    // Register map, as word indices (byte offset >> 2)
    localparam int CTRL_WORD   = 0;   // 0x000
    localparam int STATUS_WORD = 1;   // 0x004
    localparam int ARGMAX_WORD = 2;   // 0x008
    localparam int MAXVAL_WORD = 3;   // 0x00C

    localparam logic [11:0] RESULT_BASE_DEFAULT = 12'h100;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic {
        ST_CAPTURE = 1'b0,
        ST_DONE    = 1'b1
    } cap_state_e;

    // STATUS layout: [0] done, [1] overflow, [15:8] count
    function automatic logic [31:0] pack_status(input logic       done_f,
                                                input logic       ovf_f,
                                                input logic [7:0] cnt);
        return {16'h0000, cnt, 6'b000000, ovf_f, done_f};
    endfunction

endpackage

// File: rtl/result_argmax_tracker.sv
// Running signed argmax over the stored beats of one result vector.
// Keeps its own beat position so the captured index matches buffer order.
module result_argmax_tracker #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load_first,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic [IDX_W-1:0]  index,
    output logic [DATA_W-1:0] max_val
);

    logic [IDX_W-1:0] pos_q;

    // First stored beat loads unconditionally; later ones only on a strictly larger value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q   <= '0;
            index   <= '0;
            max_val <= '0;
        end else if (clear) begin
            pos_q   <= '0;
            index   <= '0;
            max_val <= '0;
        end else if (valid) begin
            pos_q <= pos_q + 1'b1;
            if (load_first || ($signed(data) > $signed(max_val))) begin
                max_val <= data;
                index   <= pos_q;
            end
        end
    end

endmodule

// File: rtl/result_capture_module.sv
// Captures the network output vector from an AXI-Stream slave into a small
// register buffer, tracks the signed argmax, and exposes results and status
// over an AXI4-Lite slave. A CTRL write of bit0 rearms capture.
module result_capture_module
    import image_pipeline_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int DEPTH              = 16,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] RESULT_BASE = RESULT_BASE_DEFAULT
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_aresetn,
    // AXI-Lite write address
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    // AXI-Lite write data
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [3:0]                      s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    // AXI-Lite write response
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    // AXI-Lite read address
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    // AXI-Lite read data
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    // Result stream in
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   y_tdata,
    input  logic                            y_tvalid,
    input  logic                            y_tlast,
    output logic                            y_tready,
    output logic                            done
);

    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int WA    = AW - 2;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [WA-1:0] BASE_W = RESULT_BASE[AW-1:2];

    cap_state_e state_q, state_d;

    logic [DEPTH-1:0][DW-1:0] res_buf;
    logic [CNT_W-1:0]         count_q;
    logic                     ovf_q;
    logic [7:0]               argmax_idx;
    logic [DW-1:0]            max_val;

    logic wr_fire, rd_fire, clear;
    logic beat_acc, has_room, store_beat;

    logic [WA-1:0]    aw_word, rd_word, rd_off;
    logic [IDX_W-1:0] rd_idx;
    logic             in_buf;
    logic [DW-1:0]    rd_mux;

    // Protection, strobes, sub-word address bits and upper CTRL bits carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb,
                           s_axi_wdata[DW-1:1], s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign s_axi_bresp = RESP_OKAY;
    assign s_axi_rresp = RESP_OKAY;

    assign wr_fire = s_axi_awvalid & s_axi_awready & s_axi_wvalid & s_axi_wready;
    assign rd_fire = s_axi_arvalid & s_axi_arready;
    assign aw_word = s_axi_awaddr[AW-1:2];
    assign clear   = wr_fire && (aw_word == WA'(CTRL_WORD)) && s_axi_wdata[0];

    assign y_tready   = (state_q == ST_CAPTURE);
    assign done       = (state_q == ST_DONE);
    assign beat_acc   = y_tvalid & y_tready;
    assign has_room   = (count_q < CNT_W'(DEPTH));
    // A beat landing on the clear edge is discarded along with the old vector
    assign store_beat = beat_acc & has_room & ~clear;

    // ------------------------------------------------------------------
    // AXI-Lite write channel
    // ------------------------------------------------------------------

    // One-cycle aw/w ready pulse per address+data pair; response held until bready
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
        end else begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            if (!s_axi_awready && s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid) begin
                s_axi_awready <= 1'b1;
                s_axi_wready  <= 1'b1;
            end
            if (wr_fire)
                s_axi_bvalid <= 1'b1;
            else if (s_axi_bready)
                s_axi_bvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // AXI-Lite read channel
    // ------------------------------------------------------------------

    assign rd_word = s_axi_araddr[AW-1:2];
    assign rd_off  = rd_word - BASE_W;
    assign in_buf  = (rd_word >= BASE_W) && (rd_off < WA'(DEPTH));
    assign rd_idx  = rd_off[IDX_W-1:0];

    // Read mux over status registers and buffer; unmapped and CTRL read as zero
    always_comb begin
        rd_mux = '0;
        if (rd_word == WA'(STATUS_WORD))
            rd_mux = DW'(pack_status(done, ovf_q, 8'(count_q)));
        else if (rd_word == WA'(ARGMAX_WORD))
            rd_mux = DW'(argmax_idx);
        else if (rd_word == WA'(MAXVAL_WORD))
            rd_mux = max_val;
        else if (in_buf)
            rd_mux = res_buf[rd_idx];
    end

    // Address accepted with a one-cycle arready pulse; rdata registered and held until rready
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
        end else begin
            s_axi_arready <= 1'b0;
            if (!s_axi_arready && s_axi_arvalid && !s_axi_rvalid)
                s_axi_arready <= 1'b1;
            if (rd_fire) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_mux;
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn)
            state_q <= ST_CAPTURE;
        else
            state_q <= state_d;
    end

    // Clear wins in any state; the final beat ends capture even when it overflows
    always_comb begin
        state_d = state_q;
        if (clear)
            state_d = ST_CAPTURE;
        else if ((state_q == ST_CAPTURE) && beat_acc && y_tlast)
            state_d = ST_DONE;
    end

    // Beat count and overflow flag
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (clear) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (beat_acc) begin
            if (has_room)
                count_q <= count_q + 1'b1;
            else
                ovf_q <= 1'b1;
        end
    end

    // Result storage; contents are don't-care until written so no reset
    always_ff @(posedge s_axi_aclk) begin
        if (store_beat)
            res_buf[count_q[IDX_W-1:0]] <= y_tdata;
    end

    result_argmax_tracker #(
        .DATA_W (DW),
        .IDX_W  (8)
    ) u_argmax (
        .clk        (s_axi_aclk),
        .rst_n      (s_axi_aresetn),
        .clear      (clear),
        .load_first (count_q == '0),
        .valid      (store_beat),
        .data       (y_tdata),
        .index      (argmax_idx),
        .max_val    (max_val)
    );

endmodule
